// File: rtl/wb_csr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_csr_arbiter_pkg
// Purpose  : State encodings, defaults and round-robin pick for the CSR arbiter
// Revision : 1.0
// ============================================================================
package wb_csr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_e;

    localparam int unsigned C_DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned C_DEF_TO_W           = 8;

    // Returns the index of the master to grant; ptr breaks a tie.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic ptr);
        if (req0 && req1) begin
            return ptr;
        end
        return !req0;
    endfunction

endpackage : wb_csr_arbiter_pkg
`default_nettype wire

// File: rtl/wb_csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_csr_arbiter
// Purpose  : Two-master round-robin Wishbone classic arbiter with hung-cycle abort
// Revision : 1.0
// ============================================================================
module wb_csr_arbiter
    import wb_csr_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES,
    parameter int unsigned TO_W           = C_DEF_TO_W
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i
);

    arb_state_e      state_q, state_d;
    logic            err_idx_q, err_idx_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic w_granted, w_gnt_idx, w_sel_cyc, w_sel_stb, w_timeout, w_err_cyc;

    assign w_granted = (state_q == ST_GNT0) || (state_q == ST_GNT1);
    assign w_gnt_idx = (state_q == ST_GNT1);
    assign w_sel_cyc = w_gnt_idx ? m1_cyc_i : m0_cyc_i;
    assign w_sel_stb = w_gnt_idx ? m1_stb_i : m0_stb_i;
    assign w_err_cyc = err_idx_q ? m1_cyc_i : m0_cyc_i;

    // A zero timeout disables the abort path entirely.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_granted && w_sel_cyc && w_sel_stb &&
                       !s_ack_i && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    // Read data is broadcast; masters qualify it with their own ack.
    assign m0_dat_o = wb_rst_n_i ? s_dat_i : '0;
    assign m1_dat_o = wb_rst_n_i ? s_dat_i : '0;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        if (w_granted) begin
            s_cyc_o  = w_sel_cyc && !w_timeout;
            s_stb_o  = w_sel_stb && !w_timeout;
            s_we_o   = w_gnt_idx ? m1_we_i  : m0_we_i;
            s_sel_o  = w_gnt_idx ? m1_sel_i : m0_sel_i;
            s_adr_o  = w_gnt_idx ? m1_adr_i : m0_adr_i;
            s_dat_o  = w_gnt_idx ? m1_dat_i : m0_dat_i;
            m0_ack_o = !w_gnt_idx && s_ack_i;
            m1_ack_o = w_gnt_idx && s_ack_i;
            m0_err_o = !w_gnt_idx && w_timeout;
            m1_err_o = w_gnt_idx && w_timeout;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_idx_d = err_idx_q;
        rr_ptr_d  = rr_ptr_q;
        to_cnt_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_d = rr_pick(m0_cyc_i, m1_cyc_i, rr_ptr_q) ? ST_GNT1 : ST_GNT0;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (!w_sel_cyc) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = !w_gnt_idx;
                end else if (w_timeout) begin
                    state_d   = ST_ERR;
                    err_idx_d = w_gnt_idx;
                    rr_ptr_d  = !w_gnt_idx;
                end else if (w_sel_stb && !s_ack_i) begin
                    to_cnt_d = (to_cnt_q == {TO_W{1'b1}}) ? to_cnt_q : to_cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                if (!w_err_cyc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            err_idx_q <= 1'b0;
            rr_ptr_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            err_idx_q <= err_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

endmodule : wb_csr_arbiter
`default_nettype wire

// File: tb/tb_wb_csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_csr_arbiter
// Purpose  : Directed self-checking bench for wb_csr_arbiter (timeout 4 and disabled)
// Revision : 1.0
// ============================================================================
module tb_wb_csr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;

    logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
    logic [31:0] m0_rd, m1_rd, s_adr, s_wd;
    logic [3:0]  s_sel;

    logic        n_m0_ack, n_m0_err, n_m1_ack, n_m1_err, n_s_cyc, n_s_stb, n_s_we;
    logic [31:0] n_m0_rd, n_m1_rd, n_s_adr, n_s_wd;
    logic [3:0]  n_s_sel;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_csr_arbiter #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rd),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rd),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_wd), .s_ack_i(s_ack), .s_dat_i(s_dat)
    );

    wb_csr_arbiter #(.TIMEOUT_CYCLES(0), .TO_W(8)) dut_nt (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(n_m0_ack), .m0_err_o(n_m0_err), .m0_dat_o(n_m0_rd),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(n_m1_ack), .m1_err_o(n_m1_err), .m1_dat_o(n_m1_rd),
        .s_cyc_o(n_s_cyc), .s_stb_o(n_s_stb), .s_we_o(n_s_we), .s_sel_o(n_s_sel),
        .s_adr_o(n_s_adr), .s_dat_o(n_s_wd), .s_ack_i(s_ack), .s_dat_i(s_dat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_m0(input logic cyc, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_sel = cyc ? 4'hF : 4'h0;
        m0_adr = adr; m0_dat = dat;
    endtask

    task automatic set_m1(input logic cyc, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_sel = cyc ? 4'hF : 4'h0;
        m1_adr = adr; m1_dat = dat;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
        s_ack = 1'b0;
        s_dat = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_m0(1, 1, 32'h3000_0000, 32'h1234_5678);
        s_ack = 1'b1;
        s_dat = 32'hA5A5_A5A5;
        #3;
        n_vec++;
        if ({m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, s_sel, s_adr, s_wd, m0_rd, m1_rd} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got cyc=%b ack0=%b rd0=%h, want all 0", s_cyc, m0_ack, m0_rd);
        end
        n_vec++;
        if ({n_m0_ack, n_m0_err, n_m1_ack, n_m1_err, n_s_cyc, n_s_stb, n_s_we, n_s_sel,
             n_s_adr, n_s_wd, n_m0_rd, n_m1_rd} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_nt: got cyc=%b ack0=%b rd0=%h, want all 0", n_s_cyc, n_m0_ack, n_m0_rd);
        end
        do_reset();
        smp();
        n_vec++;
        if ({s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err} !== 6'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want 000000", {s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err});
        end
    endtask

    task automatic test_single_write();
        do_reset();
        set_m0(1, 1, 32'h3000_0008, 32'hC0A8_0001);
        smp();
        n_vec++;
        if (s_cyc !== 1'b0) begin
            n_err++;
            $display("FAIL wr_cyc_delay: got s_cyc=%b want 0", s_cyc);
        end
        step(); smp();
        n_vec++;
        if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_wd, m0_ack} !== {3'b111, 4'hF, 32'h3000_0008, 32'hC0A8_0001, 1'b0}) begin
            n_err++;
            $display("FAIL wr_mux: got cyc=%b adr=%h dat=%h ack=%b want 1 30000008 c0a80001 0", s_cyc, s_adr, s_wd, m0_ack);
        end
        step(); s_ack = 1'b1; smp();
        n_vec++;
        if ({m0_ack, m1_ack, m0_err} !== 3'b100) begin
            n_err++;
            $display("FAIL wr_ack: got ack0/ack1/err0=%b want 100", {m0_ack, m1_ack, m0_err});
        end
        step(); s_ack = 1'b0; set_m0(0, 0, 0, 0); smp();
        n_vec++;
        if ({s_cyc, m0_ack, m1_ack} !== 3'b000) begin
            n_err++;
            $display("FAIL wr_release: got cyc/ack0/ack1=%b want 000", {s_cyc, m0_ack, m1_ack});
        end
        step();
        set_m0(1, 0, 32'h3000_0010, 0);
        set_m1(1, 0, 32'h3000_0020, 0);
        step(); smp();
        n_vec++;
        if ({s_cyc, s_adr} !== {1'b1, 32'h3000_0020}) begin
            n_err++;
            $display("FAIL wr_rr_ptr1: got cyc=%b adr=%h want 1 30000020", s_cyc, s_adr);
        end
        step(); set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        set_m0(1, 0, 32'h3000_0100, 0);
        set_m1(1, 0, 32'h3000_0104, 0);
        step(); smp();
        n_vec++;
        if ({s_cyc, s_adr} !== {1'b1, 32'h3000_0100}) begin
            n_err++;
            $display("FAIL rr_first_m0: got cyc=%b adr=%h want 1 30000100", s_cyc, s_adr);
        end
        step(); s_ack = 1'b1; s_dat = 32'h1111_1111; smp();
        n_vec++;
        if ({m0_ack, m1_ack, m0_rd} !== {2'b10, 32'h1111_1111}) begin
            n_err++;
            $display("FAIL rr_m0_ack: got ack0=%b ack1=%b rd=%h want 1 0 11111111", m0_ack, m1_ack, m0_rd);
        end
        step(); s_ack = 1'b0; set_m0(0, 0, 0, 0);
        step(); smp();
        n_vec++;
        if (s_cyc !== 1'b0) begin
            n_err++;
            $display("FAIL rr_gap: got s_cyc=%b want 0", s_cyc);
        end
        step(); smp();
        n_vec++;
        if ({s_cyc, s_adr} !== {1'b1, 32'h3000_0104}) begin
            n_err++;
            $display("FAIL rr_second_m1: got cyc=%b adr=%h want 1 30000104", s_cyc, s_adr);
        end
        step(); set_m0(1, 0, 32'h3000_0100, 0); s_ack = 1'b1; s_dat = 32'h2222_2222; smp();
        n_vec++;
        if ({m1_ack, m0_ack, m1_rd} !== {2'b10, 32'h2222_2222}) begin
            n_err++;
            $display("FAIL rr_m1_ack: got ack1=%b ack0=%b rd=%h want 1 0 22222222", m1_ack, m0_ack, m1_rd);
        end
        step(); s_ack = 1'b0; set_m1(0, 0, 0, 0);
        step(); set_m1(1, 0, 32'h3000_0104, 0);
        step(); smp();
        n_vec++;
        if ({s_cyc, s_adr} !== {1'b1, 32'h3000_0100}) begin
            n_err++;
            $display("FAIL rr_third_m0: got cyc=%b adr=%h want 1 30000100", s_cyc, s_adr);
        end
        step(); set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        step(); step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{32'h3000_0000, 32'h3000_0004, 32'h3000_000C};
        datas = '{32'h0000_AAA1, 32'h0000_BBB2, 32'h0000_CCC3};
        do_reset();
        set_m1(1, 0, addrs[0], 0);
        step();
        set_m0(1, 1, 32'h3000_0200, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            m1_adr = addrs[k];
            s_dat  = datas[k];
            s_ack  = 1'b1;
            smp();
            n_vec++;
            if ({m1_ack, m0_ack, s_adr, m1_rd} !== {2'b10, addrs[k], datas[k]}) begin
                n_err++;
                $display("FAIL b2b_read%0d: got ack1=%b ack0=%b adr=%h rd=%h want 1 0 %h %h",
                         k, m1_ack, m0_ack, s_adr, m1_rd, addrs[k], datas[k]);
            end
            step();
        end
        set_m1(0, 0, 0, 0); s_ack = 1'b0;
        step(); smp();
        n_vec++;
        if ({s_cyc, m0_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_m0_blocked: got cyc=%b ack0=%b want 0 0", s_cyc, m0_ack);
        end
        step(); smp();
        n_vec++;
        if ({s_cyc, s_we, s_adr, s_wd} !== {2'b11, 32'h3000_0200, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL b2b_m0_granted: got cyc=%b we=%b adr=%h dat=%h want 1 1 30000200 deadbeef",
                     s_cyc, s_we, s_adr, s_wd);
        end
        step(); set_m0(0, 0, 0, 0);
        step(); step();
    endtask

    task automatic test_timeout();
        do_reset();
        set_m0(1, 1, 32'h3000_0300, 32'h0000_CAFE);
        step();
        for (int c = 1; c <= 5; c++) begin
            smp();
            n_vec++;
            if ({s_cyc, s_stb, m0_err, m0_ack} !== ((c < 5) ? 4'b1100 : 4'b0010)) begin
                n_err++;
                $display("FAIL to_stall%0d: got cyc/stb/err/ack=%b want %b",
                         c, {s_cyc, s_stb, m0_err, m0_ack}, (c < 5) ? 4'b1100 : 4'b0010);
            end
            step();
        end
        set_m1(1, 0, 32'h3000_0304, 0);
        smp();
        n_vec++;
        if ({s_cyc, m0_err, m1_err} !== 3'b000) begin
            n_err++;
            $display("FAIL to_err_state: got cyc/err0/err1=%b want 000", {s_cyc, m0_err, m1_err});
        end
        step(); s_ack = 1'b1; smp();
        n_vec++;
        if ({s_cyc, m0_ack, m1_ack} !== 3'b000) begin
            n_err++;
            $display("FAIL to_late_ack: got cyc/ack0/ack1=%b want 000", {s_cyc, m0_ack, m1_ack});
        end
        step(); s_ack = 1'b0; set_m0(0, 0, 0, 0);
        step(); smp();
        n_vec++;
        if (s_cyc !== 1'b0) begin
            n_err++;
            $display("FAIL to_idle: got s_cyc=%b want 0", s_cyc);
        end
        step(); smp();
        n_vec++;
        if ({s_cyc, s_adr} !== {1'b1, 32'h3000_0304}) begin
            n_err++;
            $display("FAIL to_regrant_m1: got cyc=%b adr=%h want 1 30000304", s_cyc, s_adr);
        end
        step(); set_m1(0, 0, 0, 0);
        step(); step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m1(1, 0, 32'h3000_0400, 0);
        step(); smp();
        n_vec++;
        if ({s_cyc, s_adr} !== {1'b1, 32'h3000_0400}) begin
            n_err++;
            $display("FAIL rst_mid_gnt1: got cyc=%b adr=%h want 1 30000400", s_cyc, s_adr);
        end
        #2;
        s_ack = 1'b1; s_dat = 32'h7777_7777;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, s_sel, s_adr, s_wd, m0_rd, m1_rd} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got cyc=%b ack1=%b adr=%h rd1=%h want all 0", s_cyc, m1_ack, s_adr, m1_rd);
        end
        s_ack = 1'b0;
        step();
        rst_n = 1'b1;
        set_m0(1, 0, 32'h3000_0410, 0);
        set_m1(1, 0, 32'h3000_0414, 0);
        step(); smp();
        n_vec++;
        if ({s_cyc, s_adr} !== {1'b1, 32'h3000_0410}) begin
            n_err++;
            $display("FAIL rst_mid_m0_favoured: got cyc=%b adr=%h want 1 30000410", s_cyc, s_adr);
        end
        step(); set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
        step(); step();
    endtask

    task automatic test_no_timeout();
        int errs;
        int acks;
        int cycs;
        errs = 0; acks = 0; cycs = 0;
        do_reset();
        set_m1(1, 0, 32'h3000_0500, 0);
        step();
        repeat (1000) begin
            smp();
            errs += int'(n_m0_err) + int'(n_m1_err);
            acks += int'(n_m0_ack) + int'(n_m1_ack);
            cycs += int'(n_s_cyc);
            step();
        end
        s_ack = 1'b1; s_dat = 32'h5A5A_0001;
        smp();
        n_vec++;
        if ({n_m1_ack, n_m0_ack, n_m1_err, n_m1_rd} !== {3'b100, 32'h5A5A_0001}) begin
            n_err++;
            $display("FAIL nt_final_ack: got ack1=%b ack0=%b err1=%b rd=%h want 1 0 0 5a5a0001",
                     n_m1_ack, n_m0_ack, n_m1_err, n_m1_rd);
        end
        n_vec++;
        if (errs !== 0 || acks !== 0 || cycs !== 1000) begin
            n_err++;
            $display("FAIL nt_stall: got errs=%0d acks=%0d cyc_cycles=%0d want 0 0 1000", errs, acks, cycs);
        end
        step(); s_ack = 1'b0; set_m1(0, 0, 0, 0);
        step(); step();
    endtask

    initial begin
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
        s_ack = 1'b0;
        s_dat = 32'h0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_no_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_csr_arbiter
`default_nettype wire
